// File: rtl/i2c_line_cond_if.sv
// PHY-side view of the I2C line conditioner.
// Filtered line levels, bus events and the SDA drive request/applied pair.
interface i2c_line_cond_if;
   logic sda_oe_i;
   logic scl_f;
   logic sda_f;
   logic scl_rise;
   logic scl_fall;
   logic start_det;
   logic stop_det;
   logic bus_busy;
   logic sda_oe_o;
   logic timeout;

   modport master (
      output sda_oe_i,
      input  scl_f,
      input  sda_f,
      input  scl_rise,
      input  scl_fall,
      input  start_det,
      input  stop_det,
      input  bus_busy,
      input  sda_oe_o,
      input  timeout
   );

   modport slave (
      input  sda_oe_i,
      output scl_f,
      output sda_f,
      output scl_rise,
      output scl_fall,
      output start_det,
      output stop_det,
      output bus_busy,
      output sda_oe_o,
      output timeout
   );
endinterface

// File: rtl/i2c_line_cond.sv
// I2C pin front end: sync, glitch filter, edge/START/STOP detect,
// bus-busy tracking, SCL stuck-low timeout and hold-timed SDA driver.
module i2c_line_cond #(
   parameter int SYNC_STAGES = 2,
   parameter int FILT_LEN    = 4,
   parameter int HOLD_CYC    = 8,
   parameter int TOUT_CYC    = 1000000
) (
   input  logic CLK_I,
   input  logic RST_I,
   input  logic reg_rst,
   input  logic scl_pin,
   inout  wire  sda_pin,
   i2c_line_cond_if.slave bus
);
   localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
   localparam int HW = $clog2(HOLD_CYC + 1);
   localparam int TW = $clog2(TOUT_CYC);
   localparam logic [FW-1:0] FILT_MAX = FW'(FILT_LEN - 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYC);
   localparam logic [TW-1:0] TOUT_MAX = TW'(TOUT_CYC - 1);

   typedef enum logic [1:0] {REL, DRV, PEND} drv_state_t;

   logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
   logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
   logic [1:0]             pin_s;
   logic [1:0]             filt_q, filt_d;
   logic [1:0][FW-1:0]     fcnt_q, fcnt_d;
   logic [1:0]             prev_q, prev_d;
   logic                   busy_q, busy_d;
   logic [HW-1:0]          hcnt_q, hcnt_d;
   logic [TW-1:0]          tcnt_q, tcnt_d;
   logic                   chg_q, chg_d;
   drv_state_t             state_q;
   logic                   sda_oe_q;

   logic scl_rise, scl_fall, start_det, stop_det;
   logic tout_fire, hold_ok, apply;

   always_comb begin
      scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_pin};
      sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_pin};
      pin_s      = {sda_sync_q[SYNC_STAGES-1],
                    scl_sync_q[SYNC_STAGES-1]};
   end

   // index 0 is SCL, index 1 is SDA
   always_comb begin
      filt_d = filt_q;
      fcnt_d = '0;
      for (int i = 0; i < 2; i++) begin
         if (pin_s[i] != filt_q[i]) begin
            if (fcnt_q[i] == FILT_MAX) filt_d[i] = pin_s[i];
            else fcnt_d[i] = fcnt_q[i] + 1'b1;
         end
      end
      prev_d = filt_q;
   end

   always_comb begin
      scl_rise  = filt_q[0] & ~prev_q[0];
      scl_fall  = ~filt_q[0] & prev_q[0];
      start_det = filt_q[0] & prev_q[0] & prev_q[1] & ~filt_q[1];
      stop_det  = filt_q[0] & prev_q[0] & ~prev_q[1] & filt_q[1];
      tout_fire = busy_q & ~filt_q[0] & (tcnt_q == TOUT_MAX);
   end

   always_comb begin
      busy_d = (busy_q | start_det)
             & ~(stop_det | tout_fire | reg_rst);
      tcnt_d = tcnt_q + 1'b1;
      if (reg_rst | tout_fire | ~busy_q | filt_q[0]) tcnt_d = '0;
   end

   // hcnt counts filtered-low cycles including the current one,
   // so hold_ok rises HOLD_CYC-1 cycles after scl_fall and the
   // registered drive changes HOLD_CYC cycles after it.
   always_comb begin
      hcnt_d = hcnt_q;
      if (hcnt_q != HOLD_MAX) hcnt_d = hcnt_q + 1'b1;
      if (filt_d[0] | reg_rst) hcnt_d = '0;
      hold_ok = (hcnt_q == HOLD_MAX) & ~filt_q[0] & ~chg_q;
      apply   = (state_q == PEND)
              & (bus.sda_oe_i != sda_oe_q)
              & hold_ok & ~(reg_rst | tout_fire);
      chg_d   = filt_d[0] ? 1'b0 : (chg_q | apply);
   end

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         filt_q     <= '1;
         fcnt_q     <= '0;
         prev_q     <= '1;
         busy_q     <= 1'b0;
         hcnt_q     <= '0;
         tcnt_q     <= '0;
         chg_q      <= 1'b0;
      end else begin
         scl_sync_q <= scl_sync_d;
         sda_sync_q <= sda_sync_d;
         filt_q     <= filt_d;
         fcnt_q     <= fcnt_d;
         prev_q     <= prev_d;
         busy_q     <= busy_d;
         hcnt_q     <= hcnt_d;
         tcnt_q     <= tcnt_d;
         chg_q      <= chg_d;
      end
   end

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         state_q  <= REL;
         sda_oe_q <= 1'b0;
      end else if (reg_rst | tout_fire) begin
         state_q  <= REL;
         sda_oe_q <= 1'b0;
      end else begin
         unique case (state_q)
            REL: if (bus.sda_oe_i) state_q <= PEND;
            DRV: if (!bus.sda_oe_i) state_q <= PEND;
            PEND: begin
               if (bus.sda_oe_i == sda_oe_q) begin
                  state_q <= sda_oe_q ? DRV : REL;
               end else if (apply) begin
                  sda_oe_q <= bus.sda_oe_i;
                  state_q  <= bus.sda_oe_i ? DRV : REL;
               end
            end
            default: state_q <= REL;
         endcase
      end
   end

   assign sda_pin = sda_oe_q ? 1'b0 : 1'bz;

   assign bus.scl_f     = filt_q[0];
   assign bus.sda_f     = filt_q[1];
   assign bus.scl_rise  = scl_rise;
   assign bus.scl_fall  = scl_fall;
   assign bus.start_det = start_det;
   assign bus.stop_det  = stop_det;
   assign bus.bus_busy  = busy_q;
   assign bus.sda_oe_o  = sda_oe_q;
   assign bus.timeout   = tout_fire;
endmodule

// File: tb/tb_i2c_line_cond.sv
// Bench for i2c_line_cond: history-based reference model checked every
// cycle, plus directed scenarios with hand-computed event timing.
module tb_i2c_line_cond;
   localparam int S = 2;
   localparam int F = 4;
   localparam int H = 8;
   localparam int T = 100;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic reg_rst = 1'b0;
   logic scl_tb = 1'b1;
   logic sda_tb = 1'b1;
   wire  sda_pin;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   i2c_line_cond_if bus ();

   assign sda_pin = sda_tb ? 1'bz : 1'b0;
   pullup (sda_pin);

   i2c_line_cond #(
      .SYNC_STAGES(S), .FILT_LEN(F), .HOLD_CYC(H), .TOUT_CYC(T)
   ) dut (
      .CLK_I(clk), .RST_I(rst), .reg_rst(reg_rst),
      .scl_pin(scl_tb), .sda_pin(sda_pin), .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // reference model state: expected register contents for this cycle
   bit m_scl, m_sda, m_pscl, m_psda, m_busy, m_oe, m_pend;
   bit scl_h [S+F];
   bit sda_h [S+F];
   int run_p, since_t, fall_t, last_apply;

   // DUT event log used by the directed checks
   int n_rise, n_fall, n_start, n_stop, n_tout;
   int last_rise, last_fall, last_start, last_stop, last_tout;
   int last_oe_rise, last_oe_fall;
   bit oe_prev;

   always @(negedge clk) begin
      bit e_rise, e_fall, e_start, e_stop, e_tout, hold;
      bit clr, diff, apply, nscl, nsda, all_scl, all_sda;
      int run_n;
      if (rst) begin
         m_scl = 1; m_sda = 1; m_pscl = 1; m_psda = 1;
         m_busy = 0; m_oe = 0; m_pend = 0;
         for (int i = 0; i < S + F; i++) begin
            scl_h[i] = 1; sda_h[i] = 1;
         end
         run_p = 0; since_t = 0; fall_t = 0; last_apply = -1;
         n_rise = 0; n_fall = 0; n_start = 0; n_stop = 0; n_tout = 0;
         last_rise = -1; last_fall = -1; last_start = -1;
         last_stop = -1; last_tout = -1;
         last_oe_rise = -1; last_oe_fall = -1; oe_prev = 0;
      end
      e_rise  = m_scl & ~m_pscl;
      e_fall  = ~m_scl & m_pscl;
      e_start = m_scl & m_pscl & m_psda & ~m_sda;
      e_stop  = m_scl & m_pscl & ~m_psda & m_sda;
      run_n   = (m_busy && !m_scl) ? run_p + 1 : 0;
      e_tout  = (run_n == T);
      if (e_fall) begin
         fall_t = cyc;
         if (cyc > since_t) since_t = cyc;
      end
      hold = !m_scl && (cyc >= since_t + H - 1) && (last_apply < fall_t);

      chk("scl_f", bus.scl_f, m_scl);
      chk("sda_f", bus.sda_f, m_sda);
      chk("scl_rise", bus.scl_rise, e_rise);
      chk("scl_fall", bus.scl_fall, e_fall);
      chk("start_det", bus.start_det, e_start);
      chk("stop_det", bus.stop_det, e_stop);
      chk("bus_busy", bus.bus_busy, m_busy);
      chk("sda_oe_o", bus.sda_oe_o, m_oe);
      chk("timeout", bus.timeout, e_tout);
      chk("sda_pin", sda_pin, sda_tb & ~m_oe);

      if (bus.scl_rise)  begin n_rise++;  last_rise  = cyc; end
      if (bus.scl_fall)  begin n_fall++;  last_fall  = cyc; end
      if (bus.start_det) begin n_start++; last_start = cyc; end
      if (bus.stop_det)  begin n_stop++;  last_stop  = cyc; end
      if (bus.timeout)   begin n_tout++;  last_tout  = cyc; end
      if (bus.sda_oe_o && !oe_prev) last_oe_rise = cyc;
      if (!bus.sda_oe_o && oe_prev) last_oe_fall = cyc;
      oe_prev = bus.sda_oe_o;

      if (!rst) begin
         for (int i = S + F - 1; i > 0; i--) begin
            scl_h[i] = scl_h[i-1];
            sda_h[i] = sda_h[i-1];
         end
         scl_h[0] = scl_tb;
         sda_h[0] = sda_tb & ~m_oe;
         all_scl = 1; all_sda = 1;
         for (int i = S; i < S + F; i++) begin
            if (scl_h[i] == m_scl) all_scl = 0;
            if (sda_h[i] == m_sda) all_sda = 0;
         end
         nscl = all_scl ? ~m_scl : m_scl;
         nsda = all_sda ? ~m_sda : m_sda;
         clr   = reg_rst || e_tout;
         diff  = (bus.sda_oe_i != m_oe);
         apply = m_pend && diff && hold && !clr;
         m_pend = !clr && diff && !apply;
         if (clr) m_oe = 0;
         else if (apply) begin
            m_oe = bus.sda_oe_i;
            last_apply = cyc + 1;
         end
         m_busy = (m_busy | e_start) & ~(e_stop | e_tout | reg_rst);
         if (reg_rst) since_t = cyc + 2;
         run_p = run_n;
         m_pscl = m_scl; m_psda = m_sda;
         m_scl = nscl; m_sda = nsda;
      end
   end

   initial begin
      int k, d, r;
      bus.sda_oe_i = 1'b0;
      tick(3);
      rst = 1'b0;

      // idle after reset
      tick(100);
      chk("idle_pulses", n_rise + n_fall + n_start + n_stop + n_tout, 0);
      chk("idle_sda_pin", sda_pin, 1);

      // 3-cycle SDA glitch is swallowed, 4-cycle low is a START
      sda_tb = 1'b0;
      tick(3);
      sda_tb = 1'b1;
      tick(20);
      chk("glitch_start", n_start, 0);
      k = cyc;
      sda_tb = 1'b0;
      tick(10);
      chk("start_latency", last_start, k + 6);
      chk("start_count", n_start, 1);
      chk("busy_after_start", bus.bus_busy, 1);

      // request while SCL high waits for fall + hold
      bus.sda_oe_i = 1'b1;
      tick(20);
      chk("oe_held_scl_high", bus.sda_oe_o, 0);
      k = cyc;
      scl_tb = 1'b0;
      tick(20);
      chk("fall_latency", last_fall, k + 6);
      chk("oe_rise_hold", last_oe_rise, k + 14);
      chk("sda_pin_driven", sda_pin, 0);
      sda_tb = 1'b1;
      tick(2);
      scl_tb = 1'b1;
      tick(15);
      scl_tb = 1'b0;
      tick(20);
      d = cyc;
      bus.sda_oe_i = 1'b0;
      tick(5);
      chk("oe_drop_fast", last_oe_fall, d + 2);
      chk("sda_pin_released", sda_pin, 1);

      // STOP, then simultaneous SCL/SDA changes
      sda_tb = 1'b0;
      tick(10);
      scl_tb = 1'b1;
      tick(10);
      k = cyc;
      sda_tb = 1'b1;
      tick(10);
      chk("stop_latency", last_stop, k + 6);
      chk("busy_after_stop", bus.bus_busy, 0);
      scl_tb = 1'b0; sda_tb = 1'b0;
      tick(15);
      scl_tb = 1'b1; sda_tb = 1'b1;
      tick(15);
      chk("simul_start", n_start, 1);
      chk("simul_stop", n_stop, 1);

      // SCL stuck low while driving SDA
      sda_tb = 1'b0;
      tick(10);
      bus.sda_oe_i = 1'b1;
      tick(5);
      k = cyc;
      scl_tb = 1'b0;
      tick(115);
      chk("tout_oe_rise", last_oe_rise, k + 14);
      chk("tout_cycle", last_tout, k + 105);
      chk("tout_oe_fall", last_oe_fall, k + 106);
      chk("busy_after_tout", bus.bus_busy, 0);
      tick(200);
      chk("tout_once", n_tout, 1);
      chk("oe_after_tout", bus.sda_oe_o, 0);
      bus.sda_oe_i = 1'b0;
      tick(5);
      scl_tb = 1'b1;
      tick(10);
      sda_tb = 1'b1;
      tick(10);

      // soft reset while a request is pending
      sda_tb = 1'b0;
      tick(10);
      chk("busy_before_rr", bus.bus_busy, 1);
      k = cyc;
      scl_tb = 1'b0;
      tick(8);
      bus.sda_oe_i = 1'b1;
      tick(2);
      r = cyc;
      reg_rst = 1'b1;
      tick(1);
      reg_rst = 1'b0;
      chk("rr_busy", bus.bus_busy, 0);
      chk("rr_oe", bus.sda_oe_o, 0);
      chk("rr_scl_f", bus.scl_f, 0);
      chk("rr_sda_f", bus.sda_f, 0);
      tick(5);
      chk("rr_no_fall", last_fall, k + 6);
      chk("rr_no_rise", int'(last_rise < r), 1);
      tick(10);
      bus.sda_oe_i = 1'b0;
      tick(20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
